// File: rtl/grayscale_histogram_ise.sv
// 16-bin grayscale histogram custom instruction: ACC serializes four gray bytes
// into saturating bin/total counters; RDBIN/RDTOT/CLEAR complete in one step.

module grayscale_histogram_ise_satcnt #(
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [COUNT_WIDTH-1:0] o_cnt
);
    logic [COUNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {COUNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

module grayscale_histogram_ise #(
    parameter logic [7:0] customInstructionId = 8'd14,
    parameter int         COUNT_WIDTH         = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [1:0] OP_ACC   = 2'd0;
    localparam logic [1:0] OP_RDBIN = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RDTOT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_ACC2,
        S_ACC3,
        S_DONE
    } state_t;

    state_t                        r_state;
    logic   [31:0]                 r_pix;
    logic   [1:0]                  r_op;
    logic   [3:0]                  r_idx;
    logic                          r_done;
    logic   [31:0]                 r_result;

    logic                          w_accept;
    logic                          w_acc_step;
    logic                          w_clr;
    logic   [3:0]                  w_pix_bin;
    logic   [15:0]                 w_bin_inc;
    logic   [15:0][COUNT_WIDTH-1:0] w_bin_cnt;
    logic   [COUNT_WIDTH-1:0]      w_tot_cnt;
    logic   [COUNT_WIDTH-1:0]      w_rd_val;

    // r_done gates acceptance so a read's done cycle (spent in IDLE) cannot overlap a new op.
    assign w_accept   = start && (iseId == customInstructionId) && (r_state == S_IDLE) && !r_done;
    assign w_clr      = w_accept && (valueB[1:0] == OP_CLEAR);
    assign w_acc_step = (r_state == S_ACC0) || (r_state == S_ACC1) ||
                        (r_state == S_ACC2) || (r_state == S_ACC3);
    assign w_pix_bin  = r_pix[7:4];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bin
            assign w_bin_inc[gi] = w_acc_step && (w_pix_bin == 4'(gi));

            grayscale_histogram_ise_satcnt #(.COUNT_WIDTH(COUNT_WIDTH)) u_bin (
                .clock (clock),
                .reset (reset),
                .i_clr (w_clr),
                .i_inc (w_bin_inc[gi]),
                .o_cnt (w_bin_cnt[gi])
            );
        end
    endgenerate

    grayscale_histogram_ise_satcnt #(.COUNT_WIDTH(COUNT_WIDTH)) u_total (
        .clock (clock),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_acc_step),
        .o_cnt (w_tot_cnt)
    );

    always_comb begin
        w_rd_val = w_bin_cnt[r_idx];
        if (r_op == OP_RDTOT) begin
            w_rd_val = w_tot_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pix    <= '0;
            r_op     <= OP_ACC;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done   <= 1'b0;
            r_result <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= valueB[1:0];
                        r_idx <= valueA[3:0];
                        if (valueB[1:0] == OP_ACC) begin
                            r_pix   <= valueA;
                            r_state <= S_ACC0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ACC0: begin
                    r_pix   <= r_pix >> 8;
                    r_state <= S_ACC1;
                end
                S_ACC1: begin
                    r_pix   <= r_pix >> 8;
                    r_state <= S_ACC2;
                end
                S_ACC2: begin
                    r_pix   <= r_pix >> 8;
                    r_state <= S_ACC3;
                end
                S_ACC3: begin
                    r_pix   <= r_pix >> 8;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Non-ACC ops sample counters here, after any prior ACC has fully landed.
                    r_state <= S_IDLE;
                    if (r_op != OP_ACC) begin
                        r_done <= 1'b1;
                        if ((r_op == OP_RDBIN) || (r_op == OP_RDTOT)) begin
                            r_result <= 32'(w_rd_val);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_grayscale_histogram_ise.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor checks each done pulse.

module tb_grayscale_histogram_ise;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int tests  = 0;
    int fails  = 0;
    int n_done = 0;

    logic [31:0] q_exp[$];
    string       q_name[$];

    grayscale_histogram_ise #(.customInstructionId(8'd14), .COUNT_WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                n_done++;
                tests++;
                if (q_exp.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got result %0h expected no done", result);
                end else begin
                    e  = q_exp.pop_front();
                    nm = q_name.pop_front();
                    if (result !== e) begin
                        fails++;
                        $display("FAIL %s: got %0h expected %0h", nm, result, e);
                    end
                end
            end else if (result !== 32'd0) begin
                tests++;
                fails++;
                $display("FAIL result_idle: got %0h expected 0", result);
            end
        end
    end

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] exp, input bit poke);
        int n;
        @(posedge clock); #1;
        start  = 1'b1;
        iseId  = 8'd14;
        valueA = a;
        valueB = {30'h2AAAAAAA, op};
        q_exp.push_back(exp);
        q_name.push_back(name);
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            if (poke && n == 2) begin
                start  = 1'b1;
                valueB = 32'd3;
            end
            @(posedge clock); #1;
            start = 1'b0;
            n++;
        end
        check({name, "_latency"}, 32'(n), (op == 2'd0) ? 32'd5 : 32'd2);
        @(posedge clock);
    endtask

    initial begin
        int cnt;
        reset  = 1'b1;
        start  = 1'b0;
        iseId  = 8'd0;
        valueA = 32'd0;
        valueB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        do_op("rdtot_after_reset", 2'd3, 32'd0, 32'd0, 1'b0);

        @(posedge clock); #1;
        cnt    = n_done;
        start  = 1'b1;
        iseId  = 8'd47;
        valueB = 32'd3;
        repeat (10) @(posedge clock);
        #1;
        start = 1'b0;
        check("wrong_id_no_done", 32'(n_done - cnt), 32'd0);

        do_op("acc_mixed", 2'd0, 32'hBFFA3E7F, 32'd0, 1'b0);
        do_op("rdbin7", 2'd1, 32'd7, 32'd1, 1'b0);
        do_op("rdbin3", 2'd1, 32'd3, 32'd1, 1'b0);
        do_op("rdbin15", 2'd1, 32'hFFFFFF0F, 32'd1, 1'b0);
        do_op("rdbin11", 2'd1, 32'd11, 32'd1, 1'b0);
        do_op("rdbin0", 2'd1, 32'd0, 32'd0, 1'b0);
        do_op("rdtot_mixed", 2'd3, 32'd0, 32'd4, 1'b0);

        do_op("clear_a", 2'd2, 32'd0, 32'd0, 1'b0);
        do_op("acc_ff_poke", 2'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
        do_op("acc_ff", 2'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
        do_op("rdbin15_repeat", 2'd1, 32'd15, 32'd8, 1'b0);
        do_op("rdtot_repeat", 2'd3, 32'd0, 32'd8, 1'b0);

        do_op("clear_b", 2'd2, 32'd0, 32'd0, 1'b0);
        do_op("rdbin15_cleared", 2'd1, 32'd15, 32'd0, 1'b0);
        do_op("rdtot_cleared", 2'd3, 32'd0, 32'd0, 1'b0);
        do_op("acc_zero", 2'd0, 32'h00000000, 32'd0, 1'b0);
        do_op("rdbin0_zero", 2'd1, 32'd0, 32'd4, 1'b0);

        // Abort an ACC in ACC2 with reset; no done may follow.
        @(posedge clock); #1;
        start  = 1'b1;
        iseId  = 8'd14;
        valueA = 32'h20202020;
        valueB = 32'd0;
        cnt    = n_done;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("reset_abort_no_done", 32'(n_done - cnt), 32'd0);
        do_op("rdbin2_after_abort", 2'd1, 32'd2, 32'd0, 1'b0);
        do_op("rdtot_after_abort", 2'd3, 32'd0, 32'd0, 1'b0);
        do_op("acc_after_abort", 2'd0, 32'h20202020, 32'd0, 1'b0);
        do_op("rdbin2_after_acc", 2'd1, 32'd2, 32'd4, 1'b0);

        do_op("clear_sat", 2'd2, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 63; i++) begin
            do_op("acc_sat", 2'd0, 32'h10101010, 32'd0, 1'b0);
        end
        do_op("rdbin1_252", 2'd1, 32'd1, 32'd252, 1'b0);
        do_op("acc_sat_last", 2'd0, 32'h10101010, 32'd0, 1'b0);
        do_op("rdbin1_sat", 2'd1, 32'd1, 32'd255, 1'b0);
        do_op("rdtot_sat", 2'd3, 32'd0, 32'd255, 1'b0);
        do_op("acc_past_sat", 2'd0, 32'h10101010, 32'd0, 1'b0);
        do_op("rdbin1_no_wrap", 2'd1, 32'd1, 32'd255, 1'b0);
        do_op("rdtot_no_wrap", 2'd3, 32'd0, 32'd255, 1'b0);

        repeat (5) @(posedge clock);
        #1;
        check("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
